// File: rtl/fp_sp_pkg.sv
// Shared single-precision constants and the divider state type.
package fp_sp_pkg;

    localparam int SP_EXP_W  = 8;
    localparam int SP_MANT_W = 23;
    localparam int SP_BIAS   = 127;
    localparam int SP_WORD_W = 1 + SP_EXP_W + SP_MANT_W;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] INF  = 32'h7F80_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASS,
        S_DIVIDE,
        S_NORM,
        S_FINISH
    } state_t;

endpackage

// File: rtl/fp_div_seq_if.sv
// Request/response bundle for the sequential FP divider.
interface fp_div_seq_if;
    import fp_sp_pkg::*;

    logic                 start;
    logic [SP_WORD_W-1:0] a_in;
    logic [SP_WORD_W-1:0] b_in;
    logic                 busy;
    logic                 done;
    logic [SP_WORD_W-1:0] result;
    logic                 flag_inv;
    logic                 flag_dz;
    logic                 flag_ovf;
    logic                 flag_unf;

    modport master (
        output start, a_in, b_in,
        input  busy, done, result, flag_inv, flag_dz, flag_ovf, flag_unf
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, result, flag_inv, flag_dz, flag_ovf, flag_unf
    );

endinterface

// File: rtl/fp_div_special.sv
// Operand classification and special-case result encoding for fp_div_seq.
module fp_div_special
    import fp_sp_pkg::*;
#(
    parameter int EXP_W  = SP_EXP_W,
    parameter int MANT_W = SP_MANT_W
) (
    input  logic [EXP_W+MANT_W:0] a,
    input  logic [EXP_W+MANT_W:0] b,
    output logic [EXP_W+MANT_W:0] result,
    output logic                  inv,
    output logic                  dz,
    output logic                  is_special
);

    localparam int W = EXP_W + MANT_W + 1;

    logic [EXP_W-1:0]  a_exp, b_exp;
    logic [MANT_W-1:0] a_mant, b_mant;
    logic              a_zero, a_inf, a_nan;
    logic              b_zero, b_inf, b_nan;
    logic              sign;

    assign a_exp  = a[W-2:MANT_W];
    assign b_exp  = b[W-2:MANT_W];
    assign a_mant = a[MANT_W-1:0];
    assign b_mant = b[MANT_W-1:0];

    // Denormals are flushed: a zero exponent means zero regardless of mantissa.
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == '1) && (a_mant == '0);
    assign b_inf  = (b_exp == '1) && (b_mant == '0);
    assign a_nan  = (a_exp == '1) && (a_mant != '0);
    assign b_nan  = (b_exp == '1) && (b_mant != '0);
    assign sign   = a[W-1] ^ b[W-1];

    always_comb begin
        result     = '0;
        inv        = 1'b0;
        dz         = 1'b0;
        is_special = 1'b1;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
            inv    = 1'b1;
        end else if (a_inf) begin
            result = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        end else if (b_zero) begin
            result = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            dz     = 1'b1;
        end else if (b_inf || a_zero) begin
            result = {sign, {(W-1){1'b0}}};
        end else begin
            is_special = 1'b0;
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative single-precision divider, one restoring quotient bit per clock.
// Rounding: FP_DIV_RNE_EN selects round-to-nearest-even, otherwise truncation.
module fp_div_seq
    import fp_sp_pkg::*;
#(
    parameter int EXP_W  = SP_EXP_W,
    parameter int MANT_W = SP_MANT_W,
    parameter int BIAS   = SP_BIAS
) (
    input  logic          clk,
    input  logic          rst,
    fp_div_seq_if.slave   bus
);

    localparam int W     = 1 + EXP_W + MANT_W;
    localparam int SIG_W = MANT_W + 1;
    localparam int Q_W   = MANT_W + 3;
    localparam int E_W   = EXP_W + 2;
    localparam int CNT_W = $clog2(Q_W);

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(Q_W - 1);
    localparam logic signed [E_W-1:0] E_ZERO   = '0;
    localparam logic signed [E_W-1:0] E_MAX    = E_W'((1 << EXP_W) - 1);

`ifdef FP_DIV_RNE_EN
    localparam bit RNE_EN = 1'b1;
`else
    localparam bit RNE_EN = 1'b0;
`endif

    state_t                 state, state_n;
    logic [W-1:0]           a_q, b_q;
    logic [SIG_W:0]         r;
    logic [SIG_W-1:0]       d;
    logic [Q_W-1:0]         q;
    logic signed [E_W-1:0]  e;
    logic                   sign;
    logic [CNT_W-1:0]       cnt;
    logic [W-1:0]           result_q;
    logic                   inv_q, dz_q, ovf_q, unf_q;

    logic [W-1:0]           sp_result;
    logic                   sp_inv, sp_dz, sp_is_special;

    logic                   q_bit;
    logic [SIG_W:0]         r_sub;
    logic [Q_W-1:0]         norm_q;
    logic signed [E_W-1:0]  e_norm, e_rnd;
    logic [MANT_W-1:0]      mant;
    logic                   guard, sticky, inc;
    logic [MANT_W:0]        mant_rnd;
    logic [W-1:0]           fin_result;
    logic                   fin_ovf, fin_unf;

    fp_div_special #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W)
    ) u_special (
        .a          (a_q),
        .b          (b_q),
        .result     (sp_result),
        .inv        (sp_inv),
        .dz         (sp_dz),
        .is_special (sp_is_special)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:   if (bus.start) state_n = S_CLASS;
            S_CLASS:  state_n = sp_is_special ? S_FINISH : S_DIVIDE;
            S_DIVIDE: if (cnt == CNT_LAST) state_n = S_NORM;
            S_NORM:   state_n = S_FINISH;
            S_FINISH: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_comb begin
        q_bit = (r >= {1'b0, d});
        r_sub = q_bit ? (r - {1'b0, d}) : r;
    end

    // Normalise, then derive guard/sticky from whatever falls below the stored mantissa.
    always_comb begin
        norm_q     = q[Q_W-1] ? q : {q[Q_W-2:0], 1'b0};
        e_norm     = q[Q_W-1] ? e : e - E_W'(1);
        mant       = norm_q[Q_W-2:2];
        guard      = norm_q[1];
        sticky     = norm_q[0] | (r != '0);
        inc        = RNE_EN & guard & (sticky | mant[0]);
        mant_rnd   = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
        e_rnd      = e_norm + E_W'(mant_rnd[MANT_W]);
        fin_result = '0;
        fin_ovf    = 1'b0;
        fin_unf    = 1'b0;
        if (e_norm <= E_ZERO) begin
            fin_result = {sign, {(W-1){1'b0}}};
            fin_unf    = 1'b1;
        end else if (e_rnd >= E_MAX) begin
            fin_result = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            fin_ovf    = 1'b1;
        end else begin
            fin_result = {sign, e_rnd[EXP_W-1:0], mant_rnd[MANT_W-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r        <= '0;
            d        <= '0;
            q        <= '0;
            e        <= '0;
            sign     <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            inv_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q <= bus.a_in;
                        b_q <= bus.b_in;
                    end
                end
                S_CLASS: begin
                    r    <= {2'b01, a_q[MANT_W-1:0]};
                    d    <= {1'b1, b_q[MANT_W-1:0]};
                    q    <= '0;
                    cnt  <= '0;
                    e    <= E_W'(a_q[W-2:MANT_W]) - E_W'(b_q[W-2:MANT_W]) + E_W'(BIAS);
                    sign <= a_q[W-1] ^ b_q[W-1];
                    if (sp_is_special) begin
                        result_q <= sp_result;
                        inv_q    <= sp_inv;
                        dz_q     <= sp_dz;
                        ovf_q    <= 1'b0;
                        unf_q    <= 1'b0;
                    end
                end
                S_DIVIDE: begin
                    r   <= r_sub << 1;
                    q   <= {q[Q_W-2:0], q_bit};
                    cnt <= cnt + CNT_W'(1);
                end
                S_NORM: begin
                    result_q <= fin_result;
                    inv_q    <= 1'b0;
                    dz_q     <= 1'b0;
                    ovf_q    <= fin_ovf;
                    unf_q    <= fin_unf;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = (state == S_FINISH);
    assign bus.result   = result_q;
    assign bus.flag_inv = inv_q;
    assign bus.flag_dz  = dz_q;
    assign bus.flag_ovf = ovf_q;
    assign bus.flag_unf = unf_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed corner cases plus random operands
// checked against an integer-arithmetic reference quotient.
module tb_fp_div_seq;
    import fp_sp_pkg::*;

`ifdef FP_DIV_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fp_div_seq_if bus ();

    fp_div_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // flags = {inv, dz, ovf, unf}
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic [3:0] flags,
                           output int lat);
        int     ea, eb, e;
        longint ma, mb, num, qv, rm, mant;
        bit     a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sgn, guard, sticky;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        sgn    = a[31] ^ b[31];
        flags  = 4'b0000;
        lat    = 2;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            res = QNAN; flags = 4'b1000;
        end else if (a_inf) begin
            res = {sgn, 8'hFF, 23'h0};
        end else if (b_zero) begin
            res = {sgn, 8'hFF, 23'h0}; flags = 4'b0100;
        end else if (b_inf || a_zero) begin
            res = {sgn, 31'h0};
        end else begin
            lat = 29;
            ma  = longint'(a[22:0]) + (64'd1 << 23);
            mb  = longint'(b[22:0]) + (64'd1 << 23);
            num = ma << 25;
            qv  = num / mb;
            rm  = num % mb;
            e   = ea - eb + 127;
            if (qv < (64'd1 << 25)) begin
                qv = qv << 1;
                e  = e - 1;
            end
            mant   = (qv >> 2) & 64'h7F_FFFF;
            guard  = ((qv >> 1) & 1) != 0;
            sticky = ((qv & 1) != 0) || (rm != 0);
            if (e <= 0) begin
                res = {sgn, 31'h0}; flags = 4'b0001;
            end else begin
                if (RNE && guard && (sticky || (mant & 1) != 0)) mant = mant + 1;
                if (mant == (64'd1 << 23)) begin
                    mant = 0;
                    e    = e + 1;
                end
                if (e >= 255) begin
                    res = {sgn, 8'hFF, 23'h0}; flags = 4'b0010;
                end else begin
                    res = {sgn, 8'(e), 23'(mant)};
                end
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic [3:0] exp_flags,
                          input int exp_lat, input bit poke);
        int n;
        bit seen;
        @(negedge clk);
        chk({tag, "/idle_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "/idle_done"}, 32'(bus.done), 32'd0);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                bus.start = 1'b0;
                bus.a_in  = $urandom;
                bus.b_in  = $urandom;
                chk({tag, "/busy"}, 32'(bus.busy), 32'd1);
            end
            if (poke && n == 5) begin
                bus.start = 1'b1;
                bus.a_in  = 32'h3F80_0000;
                bus.b_in  = 32'h0000_0000;
            end
            if (poke && n == 6) bus.start = 1'b0;
            if (bus.done) seen = 1'b1;
        end
        chk({tag, "/latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "/result"}, bus.result, exp_res);
        chk({tag, "/flags"}, {28'h0, bus.flag_inv, bus.flag_dz, bus.flag_ovf, bus.flag_unf},
            {28'h0, exp_flags});
    endtask

    function automatic logic [31:0] rand_op();
        logic [7:0]  ex;
        logic [22:0] mt;
        int          sel;
        sel = $urandom_range(0, 15);
        mt  = 23'($urandom);
        if (sel == 0)       ex = 8'h00;
        else if (sel == 1) begin
            ex = 8'hFF;
            if ($urandom_range(0, 1) == 0) mt = '0;
        end
        else if (sel == 2)  ex = 8'hFE;
        else if (sel == 3)  ex = 8'h01;
        else                ex = 8'($urandom_range(100, 154));
        return {1'($urandom), ex, mt};
    endfunction

    initial begin
        logic [31:0] a, b, res;
        logic [3:0]  flg;
        int          lat, hits;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        repeat (3) @(negedge clk);
        chk("rst/busy", 32'(bus.busy), 32'd0);
        chk("rst/done", 32'(bus.done), 32'd0);
        chk("rst/result", bus.result, 32'h0);
        chk("rst/flags", {28'h0, bus.flag_inv, bus.flag_dz, bus.flag_ovf, bus.flag_unf}, 32'h0);
        rst = 1'b0;

        run_op("6div2", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 29, 1'b0);
        run_op("1div3", 32'h3F80_0000, 32'h4040_0000,
               RNE ? 32'h3EAA_AAAB : 32'h3EAA_AAAA, 4'b0000, 29, 1'b0);
        run_op("1div0", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0100, 2, 1'b0);
        run_op("m1div0", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 4'b0100, 2, 1'b0);
        run_op("0div0", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 2, 1'b0);
        run_op("infdivinf", 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b1000, 2, 1'b0);
        run_op("nandiv1", 32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 2, 1'b0);
        run_op("infdiv2", 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, 2, 1'b0);
        run_op("2divinf", 32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 4'b0000, 2, 1'b0);
        run_op("m0div5", 32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 4'b0000, 2, 1'b0);
        run_op("ovf", 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 4'b0010, 29, 1'b0);
        run_op("unf", 32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 4'b0001, 29, 1'b0);
        run_op("poke", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 29, 1'b1);

        for (int i = 0; i < 40; i++) begin
            a = rand_op();
            b = rand_op();
            ref_div(a, b, res, flg, lat);
            run_op($sformatf("rand%0d", i), a, b, res, flg, lat, 1'b0);
        end

        // Abort a divide partway through: nothing may complete afterwards.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = 32'h40C0_0000;
        bus.b_in  = 32'h4000_0000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort/busy", 32'(bus.busy), 32'd0);
        chk("abort/result", bus.result, 32'h0);
        chk("abort/flags", {28'h0, bus.flag_inv, bus.flag_dz, bus.flag_ovf, bus.flag_unf}, 32'h0);
        hits = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) hits++;
        end
        chk("abort/no_done", 32'(hits), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
